// File: rtl/tcu_fedp_arbiter_pkg.sv
// rtl/tcu_fedp_arbiter_pkg.sv - shared TCU constants, format encodings and FEDP arbiter slot type
package tcu_fedp_arbiter_pkg;

    localparam int TCU_MAX_INPUTS = 8;

    localparam logic [3:0] TCU_FMT_FP32 = 4'd0;
    localparam logic [3:0] TCU_FMT_FP16 = 4'd1;
    localparam logic [3:0] TCU_FMT_BF16 = 4'd2;
    localparam logic [3:0] TCU_FMT_I8   = 4'd3;

    // Slot fields are sized for the largest supported arbiter; instances use the low bits.
    localparam int FEDP_ARB_IDX_MAX_W = 8;
    localparam int FEDP_ARB_TAG_MAX_W = 16;

    typedef struct packed {
        logic                          valid;
        logic [FEDP_ARB_IDX_MAX_W-1:0] idx;
        logic [FEDP_ARB_TAG_MAX_W-1:0] tag;
    } fedp_arb_slot_t;

endpackage

// File: rtl/tcu_rr_arbiter.sv
// rtl/tcu_rr_arbiter.sv - combinational round-robin pick starting at a supplied pointer
module tcu_rr_arbiter #(
    parameter int NUM_REQS = 4,
    parameter int IDX_W    = $clog2(NUM_REQS)
) (
    input  logic [NUM_REQS-1:0] req,
    input  logic [IDX_W-1:0]    ptr,
    output logic [NUM_REQS-1:0] grant_oh,
    output logic [IDX_W-1:0]    grant_idx,
    output logic                grant_valid
);

    always_comb begin : scan
        logic [IDX_W:0]   pos;
        logic [IDX_W-1:0] cand;
        pos         = '0;
        cand        = '0;
        grant_oh    = '0;
        grant_idx   = '0;
        grant_valid = 1'b0;
        for (int i = 0; i < NUM_REQS; i++) begin
            pos = {1'b0, ptr} + (IDX_W+1)'(i);
            if (pos >= (IDX_W+1)'(NUM_REQS)) begin
                pos = pos - (IDX_W+1)'(NUM_REQS);
            end
            cand = pos[IDX_W-1:0];
            if (!grant_valid && req[cand]) begin
                grant_valid    = 1'b1;
                grant_idx      = cand;
                grant_oh[cand] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/tcu_fedp_arbiter.sv
// rtl/tcu_fedp_arbiter.sv - round-robin sharing of one fixed-latency FEDP pipeline
// with a shadow pipeline carrying requester index and tag alongside the datapath.
module tcu_fedp_arbiter
    import tcu_fedp_arbiter_pkg::*;
#(
    parameter int NUM_REQS = 4,
    parameter int N        = 2,
    parameter int LATENCY  = 4,
    parameter int TAG_W    = 8,
    parameter int IDX_W    = $clog2(NUM_REQS)
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic [NUM_REQS-1:0]           req_valid,
    output logic [NUM_REQS-1:0]           req_ready,
    input  logic [NUM_REQS*4-1:0]         req_fmt_s,
    input  logic [NUM_REQS*N*32-1:0]      req_a_row,
    input  logic [NUM_REQS*N*32-1:0]      req_b_col,
    input  logic [NUM_REQS*32-1:0]        req_c_val,
    input  logic [NUM_REQS*TAG_W-1:0]     req_tag,
    output logic                          fedp_enable,
    output logic [TCU_MAX_INPUTS-1:0]     fedp_vld_mask,
    output logic [3:0]                    fedp_fmt_s,
    output logic [N*32-1:0]               fedp_a_row,
    output logic [N*32-1:0]               fedp_b_col,
    output logic [31:0]                   fedp_c_val,
    input  logic [31:0]                   fedp_d_val,
    output logic                          rsp_valid,
    input  logic                          rsp_ready,
    output logic [IDX_W-1:0]              rsp_idx,
    output logic [TAG_W-1:0]              rsp_tag,
    output logic [31:0]                   rsp_d_val,
    output logic [$clog2(LATENCY+1)-1:0]  inflight
);

    localparam int CNT_W = $clog2(LATENCY+1);

    fedp_arb_slot_t   slots_q [LATENCY];
    fedp_arb_slot_t   slots_d [LATENCY];
    fedp_arb_slot_t   head;
    logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
    logic [CNT_W-1:0] inflight_q, inflight_d;

    logic [NUM_REQS-1:0] grant_oh;
    logic [IDX_W-1:0]    grant_idx;
    logic                grant_valid;
    logic                stall;
    logic                issue;
    logic                retire;
    logic                unused_head_bits;

    tcu_rr_arbiter #(
        .NUM_REQS (NUM_REQS),
        .IDX_W    (IDX_W)
    ) u_rr (
        .req         (req_valid),
        .ptr         (rr_ptr_q),
        .grant_oh    (grant_oh),
        .grant_idx   (grant_idx),
        .grant_valid (grant_valid)
    );

    assign head             = slots_q[LATENCY-1];
    assign unused_head_bits = ^{head.idx, head.tag};

    // A bubble at the head never stalls; only an unaccepted result freezes the datapath.
    assign stall       = head.valid & ~rsp_ready;
    assign fedp_enable = ~stall;
    assign issue       = grant_valid & fedp_enable & ~reset;
    assign retire      = head.valid & rsp_ready;

    assign rsp_valid = head.valid;
    assign rsp_idx   = head.idx[IDX_W-1:0];
    assign rsp_tag   = head.tag[TAG_W-1:0];
    assign rsp_d_val = fedp_d_val;
    assign inflight  = inflight_q;

    always_comb begin
        req_ready     = '0;
        fedp_vld_mask = '0;
        fedp_fmt_s    = '0;
        fedp_a_row    = '0;
        fedp_b_col    = '0;
        fedp_c_val    = '0;
        if (issue) begin
            req_ready     = grant_oh;
            fedp_vld_mask = '1;
            fedp_fmt_s    = req_fmt_s[int'(grant_idx)*4 +: 4];
            fedp_a_row    = req_a_row[int'(grant_idx)*N*32 +: N*32];
            fedp_b_col    = req_b_col[int'(grant_idx)*N*32 +: N*32];
            fedp_c_val    = req_c_val[int'(grant_idx)*32 +: 32];
        end
    end

    always_comb begin
        slots_d    = slots_q;
        rr_ptr_d   = rr_ptr_q;
        inflight_d = inflight_q;
        if (fedp_enable) begin
            slots_d[0] = '0;
            if (issue) begin
                slots_d[0].valid = 1'b1;
                slots_d[0].idx   = FEDP_ARB_IDX_MAX_W'(grant_idx);
                slots_d[0].tag   = FEDP_ARB_TAG_MAX_W'(req_tag[int'(grant_idx)*TAG_W +: TAG_W]);
            end
            for (int k = 1; k < LATENCY; k++) begin
                slots_d[k] = slots_q[k-1];
            end
            inflight_d = inflight_q + CNT_W'(issue) - CNT_W'(retire);
        end
        if (issue) begin
            rr_ptr_d = (grant_idx == IDX_W'(NUM_REQS-1)) ? '0 : grant_idx + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LATENCY; k++) begin
                slots_q[k] <= '0;
            end
            rr_ptr_q   <= '0;
            inflight_q <= '0;
        end else begin
            slots_q    <= slots_d;
            rr_ptr_q   <= rr_ptr_d;
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: tb/tb_tcu_fedp_arbiter.sv
// tb/tb_tcu_fedp_arbiter.sv - directed vector bench for tcu_fedp_arbiter with a FEDP pipeline model
module tb_tcu_fedp_arbiter;

    localparam int NR  = 4;
    localparam int N   = 2;
    localparam int LAT = 4;
    localparam int TW  = 8;
    localparam int MI  = 8;

    logic              clk = 1'b0;
    logic              reset;
    logic [NR-1:0]     req_valid;
    logic [NR-1:0]     req_ready;
    logic [NR*4-1:0]   req_fmt_s;
    logic [NR*N*32-1:0] req_a_row;
    logic [NR*N*32-1:0] req_b_col;
    logic [NR*32-1:0]  req_c_val;
    logic [NR*TW-1:0]  req_tag;
    logic              fedp_enable;
    logic [MI-1:0]     fedp_vld_mask;
    logic [3:0]        fedp_fmt_s;
    logic [N*32-1:0]   fedp_a_row;
    logic [N*32-1:0]   fedp_b_col;
    logic [31:0]       fedp_c_val;
    logic [31:0]       fedp_d_val;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [1:0]        rsp_idx;
    logic [TW-1:0]     rsp_tag;
    logic [31:0]       rsp_d_val;
    logic [2:0]        inflight;

    always #5 clk = ~clk;

    tcu_fedp_arbiter #(.NUM_REQS(NR), .N(N), .LATENCY(LAT), .TAG_W(TW)) dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_fmt_s(req_fmt_s), .req_a_row(req_a_row), .req_b_col(req_b_col),
        .req_c_val(req_c_val), .req_tag(req_tag),
        .fedp_enable(fedp_enable), .fedp_vld_mask(fedp_vld_mask),
        .fedp_fmt_s(fedp_fmt_s), .fedp_a_row(fedp_a_row), .fedp_b_col(fedp_b_col),
        .fedp_c_val(fedp_c_val), .fedp_d_val(fedp_d_val),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_idx(rsp_idx),
        .rsp_tag(rsp_tag), .rsp_d_val(rsp_d_val), .inflight(inflight)
    );

    // FEDP stand-in: integer dot product plus C plus fmt, LAT register stages, frozen when disabled.
    logic [31:0] fedp_pipe [LAT];

    function automatic logic [31:0] fedp_fn(input logic [3:0] f, input logic [63:0] a,
                                            input logic [63:0] b, input logic [31:0] c);
        return c + a[31:0] * b[31:0] + a[63:32] * b[63:32] + {28'd0, f};
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            for (int k = 0; k < LAT; k++) fedp_pipe[k] <= 32'd0;
        end else if (fedp_enable) begin
            fedp_pipe[0] <= (|fedp_vld_mask) ? fedp_fn(fedp_fmt_s, fedp_a_row, fedp_b_col, fedp_c_val) : 32'd0;
            for (int k = 1; k < LAT; k++) fedp_pipe[k] <= fedp_pipe[k-1];
        end
    end
    assign fedp_d_val = fedp_pipe[LAT-1];

    typedef struct {
        logic [3:0] rv;
        logic       rr;
        logic [3:0] rdy;
        logic       en;
        logic       vld;
        logic [1:0] idx;
        logic [2:0] infl;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;
    logic [31:0] exp_d [NR];

    task automatic add(input logic [3:0] rv, input logic rr, input logic [3:0] rdy, input logic en,
                       input logic vld, input logic [1:0] idx, input logic [2:0] infl);
        vec_t v;
        v.rv = rv; v.rr = rr; v.rdy = rdy; v.en = en; v.vld = vld; v.idx = idx; v.infl = infl;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    function automatic int oh2idx(input logic [3:0] oh);
        for (int i = 0; i < NR; i++) if (oh[i]) return i;
        return 0;
    endfunction

    initial begin
        // Requester r: a = {r+2, r+1}, b = {5+r, 3}, c = 100r+7, fmt = r, tag = 0x58+r.
        for (int r = 0; r < NR; r++) begin
            req_a_row[(r*N+0)*32 +: 32] = 32'(r + 1);
            req_a_row[(r*N+1)*32 +: 32] = 32'(r + 2);
            req_b_col[(r*N+0)*32 +: 32] = 32'd3;
            req_b_col[(r*N+1)*32 +: 32] = 32'(5 + r);
            req_c_val[r*32 +: 32]       = 32'(100 * r + 7);
            req_fmt_s[r*4 +: 4]         = 4'(r);
            req_tag[r*TW +: TW]         = 8'(8'h58 + r);
        end
        exp_d[0] = 32'd20; exp_d[1] = 32'd132; exp_d[2] = 32'd246; exp_d[3] = 32'd362;

        //   rv      rr    rdy     en    vld   idx infl
        add(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 0, 0);  // reset state
        add(4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, 0, 0);  // single request from 2
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 0, 1);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 0, 1);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 0, 1);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2, 1);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 0, 0);
        add(4'b1001, 1'b1, 4'b1000, 1'b1, 1'b0, 0, 0);  // wrap: ptr=3, grants 3,0,3
        add(4'b1001, 1'b1, 4'b0001, 1'b1, 1'b0, 0, 1);
        add(4'b1001, 1'b1, 4'b1000, 1'b1, 1'b0, 0, 2);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 0, 3);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 3, 3);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 0, 2);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 3, 1);
        add(4'b1111, 1'b1, 4'b0001, 1'b1, 1'b0, 0, 0);  // all valid, full throughput
        add(4'b1111, 1'b1, 4'b0010, 1'b1, 1'b0, 0, 1);
        add(4'b1111, 1'b1, 4'b0100, 1'b1, 1'b0, 0, 2);
        add(4'b1111, 1'b1, 4'b1000, 1'b1, 1'b0, 0, 3);
        add(4'b1111, 1'b1, 4'b0001, 1'b1, 1'b1, 0, 4);
        add(4'b1111, 1'b1, 4'b0010, 1'b1, 1'b1, 1, 4);
        add(4'b1111, 1'b1, 4'b0100, 1'b1, 1'b1, 2, 4);
        add(4'b1111, 1'b1, 4'b1000, 1'b1, 1'b1, 3, 4);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 0, 4);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 1, 3);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2, 2);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 3, 1);
        add(4'b0010, 1'b1, 4'b0010, 1'b1, 1'b0, 0, 0);  // backpressure: issue 1 then 2
        add(4'b0100, 1'b1, 4'b0100, 1'b1, 1'b0, 0, 1);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 0, 2);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 0, 2);
        add(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 1, 2);
        add(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 1, 2);
        add(4'b0001, 1'b0, 4'b0000, 1'b0, 1'b1, 1, 2);
        add(4'b0001, 1'b1, 4'b0001, 1'b1, 1'b1, 1, 2);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 2, 2);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 0, 1);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 0, 1);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 0, 1);
        add(4'b0010, 1'b1, 4'b0010, 1'b1, 1'b0, 0, 0);  // bubble: issues at 0 and 2
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 0, 1);
        add(4'b1000, 1'b1, 4'b1000, 1'b1, 1'b0, 0, 1);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 0, 2);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 1, 2);
        add(4'b0000, 1'b0, 4'b0000, 1'b1, 1'b0, 0, 1);
        add(4'b0000, 1'b0, 4'b0000, 1'b0, 1'b1, 3, 1);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b1, 3, 1);
        add(4'b0000, 1'b1, 4'b0000, 1'b1, 1'b0, 0, 0);

        reset = 1'b1; req_valid = '0; rsp_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic ok;
            logic [63:0] ea;
            logic [31:0] ec;
            int g;
            v = vecs[i];
            req_valid = v.rv;
            rsp_ready = v.rr;
            @(negedge clk);
            g  = oh2idx(v.rdy);
            ea = (v.rdy != 0) ? {32'(g + 2), 32'(g + 1)} : 64'd0;
            ec = (v.rdy != 0) ? 32'(100 * g + 7) : 32'd0;
            ok = (req_ready === v.rdy) && (fedp_enable === v.en) && (rsp_valid === v.vld)
              && (inflight === v.infl) && (fedp_a_row === ea) && (fedp_c_val === ec)
              && (fedp_vld_mask === ((v.rdy != 0) ? 8'hFF : 8'h00));
            if (v.vld) begin
                ok = ok && (rsp_idx === v.idx) && (rsp_tag === 8'(8'h58 + v.idx))
                        && (rsp_d_val === exp_d[v.idx]);
            end
            n_vec++;
            if (!ok) begin
                n_bad++;
                $display("FAIL vec%0d (actual/required): ready=%b/%b en=%b/%b vld=%b/%b idx=%0d/%0d tag=%h d=%0d/%0d inflight=%0d/%0d mask=%h a=%h/%h",
                         i, req_ready, v.rdy, fedp_enable, v.en, rsp_valid, v.vld, rsp_idx, v.idx,
                         rsp_tag, rsp_d_val, exp_d[v.idx], inflight, v.infl, fedp_vld_mask, fedp_a_row, ea);
            end
            @(posedge clk);
            #1;
        end

        // Reset with three results in flight.
        for (int i = 0; i < 3; i++) begin
            req_valid = 4'hF; rsp_ready = 1'b1;
            @(negedge clk);
            chk("mid_grant", 32'(req_ready), 32'(1 << i));
            @(posedge clk);
            #1;
        end
        req_valid = '0;
        reset = 1'b1;
        @(negedge clk);
        chk("mid_inflight_before_reset", 32'(inflight), 32'd3);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        chk("post_reset_rsp_valid", 32'(rsp_valid), 32'd0);
        chk("post_reset_inflight", 32'(inflight), 32'd0);
        chk("post_reset_enable", 32'(fedp_enable), 32'd1);
        chk("post_reset_vld_mask", 32'(fedp_vld_mask), 32'd0);
        for (int k = 0; k < LAT; k++) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            chk("no_stale_rsp", 32'(rsp_valid), 32'd0);
        end
        @(posedge clk);
        #1 req_valid = 4'hF;
        @(negedge clk);
        chk("ptr_after_reset", 32'(req_ready), 32'd1);
        @(posedge clk);
        #1 req_valid = '0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/tcu_fedp_arbiter.md
Name: tcu_fedp_arbiter

Overview:
- Shares one fixed-latency FEDP dot-product pipeline among NUM_REQS requesters, e.g. multiple warps or tile sub-blocks.
- Grants one request per cycle using round-robin, drives the FEDP operand and format inputs, and tracks the requester index and tag through a shadow pipeline matching FEDP latency.
- Returns each FEDP result on a single valid/ready response port.
- Applies backpressure by deasserting the FEDP enable, which freezes the whole datapath.

Parameters:
- NUM_REQS, 4, number of requesters (≥2).
- N, 2, operand words per a_row/b_col; must match the FEDP instance.
- LATENCY, 4, FEDP pipeline depth in cycles; must equal the FEDP total latency (≥1).
- TAG_W, 8, opaque requester tag width.
- IDX_W, $clog2(NUM_REQS), derived requester index width.

Ports:
- clk  in  1  clock
- reset  in  1  reset
- req_valid  in  NUM_REQS  per-requester request valid
- req_ready  out  NUM_REQS  per-requester accept
- req_fmt_s  in  NUM_REQS×4  source format
- req_a_row  in  NUM_REQS×N×32  A operands
- req_b_col  in  NUM_REQS×N×32  B operands
- req_c_val  in  NUM_REQS×32  accumulator input
- req_tag  in  NUM_REQS×TAG_W  tag
- fedp_enable  out  1  FEDP pipeline advance
- fedp_vld_mask  out  TCU_MAX_INPUTS  all-ones when issuing, zero otherwise
- fedp_fmt_s  out  4  granted format
- fedp_a_row  out  N×32  granted A operands
- fedp_b_col  out  N×32  granted B operands
- fedp_c_val  out  32  granted C value
- fedp_d_val  in  32  FEDP result
- rsp_valid  out  1  result valid
- rsp_ready  in  1  consumer accept
- rsp_idx  out  IDX_W  originating requester
- rsp_tag  out  TAG_W  originating tag
- rsp_d_val  out  32  result, equal to fedp_d_val
- inflight  out  $clog2(LATENCY+1)  occupied shadow slots

Behaviour:
- Reset is synchronous, active-high, on clock clk; the same reset drives the FEDP instance.
- Reset state:
  - all shadow slots invalid;
  - RR pointer = 0, inflight = 0;
  - rsp_valid = 0, req_ready = 0;
  - fedp_vld_mask = 0, fedp_enable = 1.
- Shadow pipeline:
  - LATENCY entries of {valid, idx, tag}; slot 0 is written at issue, slot LATENCY-1 is the head.
  - It advances only when fedp_enable = 1, in lockstep with the FEDP.
- Stall rule: stall = head.valid & ~rsp_ready, and fedp_enable = ~stall.
  - An invalid head never stalls, so bubbles compress nothing but also never block.
  - The datapath holds state while disabled, so fedp_d_val is stable during a stall.
- Response:
  - rsp_valid = head.valid; rsp_idx and rsp_tag come from the head entry; rsp_d_val = fedp_d_val (combinational).
  - A handshake is rsp_valid & rsp_ready.
- Grant:
  - When fedp_enable = 1, pick the first asserted req_valid starting at the RR pointer, scanning upward with wrap.
  - req_ready[g] = fedp_enable & (g == grant) & req_valid[g]; all other bits are 0.
  - At most one bit is set, and no request is granted while stalled.
- Issue mux:
  - On a grant, drive the fedp_* operands from requester g, set fedp_vld_mask all-ones, and write {1, g, tag} into slot 0.
  - With no grant, drive operands to 0, set vld_mask to 0, and write an invalid slot 0.
- RR pointer: updates to (g+1) mod NUM_REQS on each grant and is otherwise unchanged. Wrap at NUM_REQS-1 goes to 0.
- inflight:
  - Counts the valid shadow slots.
  - On an enabled cycle it changes by +issue − (head valid handshake); it is unchanged while stalled.
- Simultaneous issue and retire in one cycle leaves inflight unchanged.
- Throughput is 1 request/cycle with no stall. A held stall blocks all requesters; the pipeline loses no results.
- Reset mid-operation drops all in-flight results with no response. The next cycle is identical to post-reset state.
- Requesters must hold req_* stable while req_valid = 1 and ready = 0 (valid/ready protocol). The arbiter does not check this.

Decomposition:
- The shared TCU package holds TCU_MAX_INPUTS and fmt encodings. Add the typedef fedp_arb_slot_t {valid, idx, tag} there.
- Natural sub-module: tcu_rr_arbiter (NUM_REQS request vector, pointer, grant one-hot/index, grant_valid), reusable elsewhere in the TCU.
- Shadow pipeline is inline shift registers with enable.

Test Plan:
- Single request: req_valid[2] = 1 with tag 0x5A at cycle 0, rsp_ready = 1 → req_ready[2] in cycle 0; rsp_valid with idx = 2, tag = 0x5A at cycle LATENCY (4); rsp_d_val matches the FEDP golden model.
- All four requesters continuously valid, rsp_ready = 1 → grants 0,1,2,3,0,… one per cycle; responses return in the same order 4 cycles later; inflight saturates at 4.
- Backpressure: two back-to-back issues, rsp_ready = 0 for 3 cycles when the first reaches the head → fedp_enable = 0 for those 3 cycles; req_ready = 0; rsp_d_val stable; both results delivered in order after release with no loss.
- Bubble tolerance: issues at cycles 0 and 2 with rsp_ready = 0 throughout cycle 5 → the bubble head at cycle 5 does not stall; stall begins only when the valid head from cycle 2 arrives at cycle 6.
- RR wrap: pointer at 3, only requesters 3 and 0 valid → grant 3, then 0, then 3; pointer after the grant to 3 equals 0.
- Reset mid-operation: assert reset with inflight = 3 → next cycle rsp_valid = 0, inflight = 0, pointer = 0, and no stale response emerges in the following LATENCY cycles.
